// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, port indices and default widths
// for the two-port line memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection between icache refill and dcache ports.
// MEM_ARB_RR_EN adds a last-served pointer for round-robin arbitration.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk_i,
  input  logic rst_i,
  input  logic take_i,
`endif
  input  logic p0_req_i,
  input  logic p1_req_i,
  output logic valid_o,
  output logic winner_o
);

`ifdef MEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (take_i && valid_o)
      last_d = winner_o;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      last_q <= PORT_ICACHE;
    else
      last_q <= last_d;
  end

  // Under contention the port not served last wins.
  always_comb begin
    valid_o  = p0_req_i | p1_req_i;
    winner_o = PORT_ICACHE;
    unique case (1'b1)
      p0_req_i && p1_req_i:  winner_o = ~last_q;
      p1_req_i && !p0_req_i: winner_o = PORT_DCACHE;
      default:               winner_o = PORT_ICACHE;
    endcase
  end
`else
  always_comb begin
    valid_o  = p0_req_i | p1_req_i;
    winner_o = p1_req_i ? PORT_DCACHE : PORT_ICACHE;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory between icache and dcache.
// Fixed priority to dcache by default; MEM_ARB_RR_EN selects round-robin.
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int LINE_W = mem_arb_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [LINE_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o
);
  import mem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              pick_valid;
  logic              pick_winner;
  logic              in_idle;
  logic              in_busy;

  assign in_idle = (state_q == IDLE);
  assign in_busy = (state_q == BUSY);

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .take_i   (in_idle),
`endif
    .p0_req_i (p0_enable_i),
    .p1_req_i (p1_enable_i),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_winner;
          wr_d    = pick_winner ? p1_write_i : p0_write_i;
          addr_d  = pick_winner ? p1_addr_i : p0_addr_i;
          data_d  = pick_winner ? p1_data_i : p0_data_i;
        end
      end
      BUSY: begin
        if (mem_ack_i)
          state_d = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Enable drops in TURN so the memory sees a gap between transactions.
  assign mem_enable_o = in_busy;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign busy_o       = !in_idle;

  assign p0_ack_o  = in_busy & mem_ack_i & (grant_q == PORT_ICACHE);
  assign p1_ack_o  = in_busy & mem_ack_i & (grant_q == PORT_DCACHE);
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a memory model
// that acks 10 cycles after enable rises.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          p0_enable_i = 1'b0;
  logic          p0_write_i = 1'b0;
  logic [AW-1:0] p0_addr_i = '0;
  logic [LW-1:0] p0_data_i = '0;
  logic          p0_ack_o;
  logic [LW-1:0] p0_data_o;
  logic          p1_enable_i = 1'b0;
  logic          p1_write_i = 1'b0;
  logic [AW-1:0] p1_addr_i = '0;
  logic [LW-1:0] p1_data_i = '0;
  logic          p1_ack_o;
  logic [LW-1:0] p1_data_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [LW-1:0] mem_data_i;
  logic          busy_o;

  logic          model_ack;
  logic          spur_ack = 1'b0;
  int            model_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            p0_acks = 0;
  int            p1_acks = 0;
  logic [LW-1:0] p0_last = '0;
  logic [LW-1:0] p1_last = '0;
  int            order[$];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_data = '0;

  mem_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p0_enable_i  (p0_enable_i),
    .p0_write_i   (p0_write_i),
    .p0_addr_i    (p0_addr_i),
    .p0_data_i    (p0_data_i),
    .p0_ack_o     (p0_ack_o),
    .p0_data_o    (p0_data_o),
    .p1_enable_i  (p1_enable_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_ack_o     (p1_ack_o),
    .p1_data_o    (p1_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  assign mem_data_i = line_of(mem_addr_o);
  assign mem_ack_i  = model_ack | spur_ack;

  // Memory: ack in the 10th cycle after enable rises.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      model_cnt <= 0;
      model_ack <= 1'b0;
    end else begin
      model_ack <= 1'b0;
      if (mem_enable_o && !model_ack) begin
        if (model_cnt == 9) begin
          model_ack <= 1'b1;
          model_cnt <= 0;
        end else begin
          model_cnt <= model_cnt + 1;
        end
      end else begin
        model_cnt <= 0;
      end
    end
  end

  always @(posedge clk_i) begin
    if (p0_ack_o) begin
      p0_acks <= p0_acks + 1;
      p0_last <= p0_data_o;
      order.push_back(0);
    end
    if (p1_ack_o) begin
      p1_acks <= p1_acks + 1;
      p1_last <= p1_data_o;
      order.push_back(1);
    end
    if (mem_ack_i && mem_enable_o && mem_write_o) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr_o;
      wr_data <= mem_data_o;
    end
  end

  task automatic test_reset();
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl en=%b busy=%b want 0 0", mem_enable_o, busy_o);
    end
    n_cmp++;
    if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ack got %b%b want 00", p0_ack_o, p1_ack_o);
    end
    n_cmp++;
    if (mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0) begin
      n_bad++;
      $display("FAIL reset_regs wr=%b addr=%h want 0 0", mem_write_o, mem_addr_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    int a0;
    int a1;
    int k;
    a0 = p0_acks;
    a1 = p1_acks;
    p1_enable_i = 1'b1;
    p1_write_i  = 1'b0;
    p1_addr_i   = 32'h0000_0400;
    n_cmp++;
    if (mem_enable_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pre_en got %b want 0", mem_enable_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_req en=%b addr=%h wr=%b want 1 400 0",
               mem_enable_o, mem_addr_o, mem_write_o);
    end
    k = 0;
    while (p1_acks == a1 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    p1_enable_i = 1'b0;
    n_cmp++;
    if (k !== 11) begin
      n_bad++;
      $display("FAIL single_latency got %0d want 11", k);
    end
    n_cmp++;
    if (p1_last !== line_of(32'h400)) begin
      n_bad++;
      $display("FAIL single_data got %h want %h", p1_last, line_of(32'h400));
    end
    repeat (5) @(negedge clk_i);
    n_cmp++;
    if (p1_acks !== a1 + 1 || p0_acks !== a0) begin
      n_bad++;
      $display("FAIL single_acks p1=%0d p0=%0d want %0d %0d",
               p1_acks - a1, p0_acks - a0, 1, 0);
    end
  endtask

  task automatic test_both();
    int a0;
    int a1;
    int k;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    a0 = p0_acks;
    a1 = p1_acks;
    p0_enable_i = 1'b1;
    p0_write_i  = 1'b0;
    p0_addr_i   = 32'h100;
    p1_enable_i = 1'b1;
    p1_write_i  = 1'b1;
    p1_addr_i   = 32'h200;
    p1_data_i   = a5;
    @(negedge clk_i);
    n_cmp++;
    if (mem_addr_o !== 32'h200 || mem_write_o !== 1'b1 || mem_data_o !== a5) begin
      n_bad++;
      $display("FAIL both_first addr=%h wr=%b want 200 1", mem_addr_o, mem_write_o);
    end
    k = 0;
    while (p1_acks == a1 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    p1_enable_i = 1'b0;
    p1_write_i  = 1'b0;
    n_cmp++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b1 || p0_acks !== a0) begin
      n_bad++;
      $display("FAIL both_turn en=%b busy=%b p0acks=%0d want 0 1 0",
               mem_enable_o, busy_o, p0_acks - a0);
    end
    @(negedge clk_i);
    n_cmp++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL both_idle en=%b busy=%b want 0 0", mem_enable_o, busy_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL both_second en=%b addr=%h wr=%b want 1 100 0",
               mem_enable_o, mem_addr_o, mem_write_o);
    end
    k = 0;
    while (p0_acks == a0 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    p0_enable_i = 1'b0;
    n_cmp++;
    if (p0_acks !== a0 + 1 || p0_last !== line_of(32'h100)) begin
      n_bad++;
      $display("FAIL both_p0 acks=%0d data=%h want 1 %h",
               p0_acks - a0, p0_last, line_of(32'h100));
    end
    n_cmp++;
    if (wr_addr !== 32'h200 || wr_data !== a5) begin
      n_bad++;
      $display("FAIL both_write addr=%h data=%h want 200 %h", wr_addr, wr_data, a5);
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_contention();
    int k;
    int exp_o[4];
`ifdef MEM_ARB_RR_EN
    exp_o = '{1, 0, 1, 0};
`else
    exp_o = '{1, 1, 1, 1};
`endif
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    order.delete();
    p0_enable_i = 1'b1;
    p0_addr_i   = 32'h700;
    p1_enable_i = 1'b1;
    p1_addr_i   = 32'h800;
    k = 0;
    while (order.size() < 4 && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    p0_enable_i = 1'b0;
    p1_enable_i = 1'b0;
    n_cmp++;
    if (order.size() < 4) begin
      n_bad++;
      $display("FAIL contend_count got %0d want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (order[i] !== exp_o[i]) begin
          n_bad++;
          $display("FAIL contend_grant%0d got %0d want %0d", i, order[i], exp_o[i]);
        end
      end
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_drop_enable();
    int a0;
    int k;
    logic stable;
    a0 = p0_acks;
    p0_enable_i = 1'b1;
    p0_write_i  = 1'b0;
    p0_addr_i   = 32'h300;
    @(negedge clk_i);
    n_cmp++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h300) begin
      n_bad++;
      $display("FAIL drop_grant en=%b addr=%h want 1 300", mem_enable_o, mem_addr_o);
    end
    repeat (3) @(negedge clk_i);
    p0_enable_i = 1'b0;
    p0_write_i  = 1'b1;
    p0_addr_i   = 32'hDEAD_0000;
    stable = 1'b1;
    k = 0;
    while (k < 30) begin
      @(negedge clk_i);
      k++;
      if (p0_acks != a0)
        break;
      if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_write_o !== 1'b0)
        stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_stable got %b want 1", stable);
    end
    repeat (5) @(negedge clk_i);
    n_cmp++;
    if (p0_acks !== a0 + 1) begin
      n_bad++;
      $display("FAIL drop_ack got %0d want 1", p0_acks - a0);
    end
    p0_write_i = 1'b0;
    p0_addr_i  = '0;
  endtask

  task automatic test_reset_mid();
    int a0;
    int a1;
    int wc;
    int k;
    a0 = p0_acks;
    a1 = p1_acks;
    wc = wr_cnt;
    p1_enable_i = 1'b1;
    p1_write_i  = 1'b1;
    p1_addr_i   = 32'h500;
    p1_data_i   = {32{8'h3C}};
    @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_enable_o !== 1'b0 || busy_o !== 1'b0 || mem_write_o !== 1'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0 ||
        p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outs en=%b busy=%b wr=%b addr=%h want all 0",
               mem_enable_o, busy_o, mem_write_o, mem_addr_o);
    end
    @(negedge clk_i);
    p1_enable_i = 1'b0;
    p1_write_i  = 1'b0;
    rst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (p1_acks !== a1 || wr_cnt !== wc) begin
      n_bad++;
      $display("FAIL midrst_noack acks=%0d writes=%0d want 0 0",
               p1_acks - a1, wr_cnt - wc);
    end
    p0_enable_i = 1'b1;
    p0_addr_i   = 32'h600;
    k = 0;
    while (p0_acks == a0 && k < 30) begin
      @(negedge clk_i);
      k++;
    end
    p0_enable_i = 1'b0;
    n_cmp++;
    if (p0_acks !== a0 + 1 || p0_last !== line_of(32'h600)) begin
      n_bad++;
      $display("FAIL midrst_after acks=%0d data=%h want 1 %h",
               p0_acks - a0, p0_last, line_of(32'h600));
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_spurious();
    int a0;
    int a1;
    a0 = p0_acks;
    a1 = p1_acks;
    spur_ack = 1'b1;
    #1;
    n_cmp++;
    if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_ack got %b%b want 00", p0_ack_o, p1_ack_o);
    end
    @(negedge clk_i);
    spur_ack = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || mem_enable_o !== 1'b0 ||
        p0_acks !== a0 || p1_acks !== a1) begin
      n_bad++;
      $display("FAIL spur_state busy=%b en=%b want 0 0", busy_o, mem_enable_o);
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_both();
    test_contention();
    test_drop_enable();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
